stall_ctrl: RTL and testbench

- Hazard/stall controller for the 5-stage pipeline.
- Computes the single stall decision that holds the PC (drives its Pause) and the IF/ID register, and injects a bubble into ID/EX.
- Tracks mult/div occupancy with a busy-countdown FSM.
- Masks PC redirects (branch/jump) while the D-stage instruction is stalled.

---
 rtl/stall_pkg.sv | 14 +
 rtl/md_busy_timer.sv | 37 +++
 rtl/stall_ctrl.sv | 62 ++++++
 tb/tb_stall_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// stall_pkg: shared encodings and the per-operand hazard test for the stall controller
package stall_pkg;
  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic MD_TYPE_MULT = 1'b0;
  localparam logic MD_TYPE_DIV = 1'b1;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;
  // Stall when an in-flight producer of r cannot deliver before the D-stage consumer needs it
  function automatic logic hazard(input logic [4:0] r, input logic [1:0] tuse,
                                  input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                  input logic [4:0] m_wa, input logic [1:0] m_tnew);
    return tuse != TUSE_NONE && r != 5'd0 &&
           ((r == e_wa && e_tnew > tuse) || (r == m_wa && m_tnew > tuse));
  endfunction
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: counts down mult/div occupancy after a start pulse; starts while busy are ignored
module md_busy_timer
  import stall_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic Type,
  output logic Busy
);
  md_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= MD_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == MD_IDLE && Start) begin
      state_nx = MD_BUSY;
      cnt_nx = Type == MD_TYPE_DIV ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      state_nx = cnt == CNT_W'(1) ? MD_IDLE : MD_BUSY;
      cnt_nx = cnt - CNT_W'(1);
    end
  end
  always_comb Busy = state == MD_BUSY;
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/bubble/redirect-mask decision with mult/div occupancy tracking
// STALL_PERF_EN adds data-stall and md-stall cycle counters on the Perf outputs
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  D_Rs_In,
  input  logic [4:0]  D_Rt_In,
  input  logic [1:0]  D_Tuse_Rs_In,
  input  logic [1:0]  D_Tuse_Rt_In,
  input  logic        D_Is_Md_In,
  input  logic [4:0]  E_Wa_In,
  input  logic [1:0]  E_Tnew_In,
  input  logic [4:0]  M_Wa_In,
  input  logic [1:0]  M_Tnew_In,
  input  logic        E_Md_Start_In,
  input  logic        E_Md_Type_In,
  output logic        Pause_Out,
  output logic        D_Hold_Out,
  output logic        E_Flush_Out,
  output logic        Redirect_En_Out,
  output logic        Md_Busy_Out,
  output logic [31:0] Perf_Data_Stall_Out,
  output logic [31:0] Perf_Md_Stall_Out
);
  logic data_stall, md_stall, stall;
  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_timer (
    .Clk(Clk), .Reset(Reset), .Start(E_Md_Start_In), .Type(E_Md_Type_In), .Busy(Md_Busy_Out)
  );
  // Reset masks everything so the pipeline never sees a stall while being cleared
  always_comb begin
    data_stall = ~Reset & (hazard(D_Rs_In, D_Tuse_Rs_In, E_Wa_In, E_Tnew_In, M_Wa_In, M_Tnew_In) |
                           hazard(D_Rt_In, D_Tuse_Rt_In, E_Wa_In, E_Tnew_In, M_Wa_In, M_Tnew_In));
    md_stall = ~Reset & D_Is_Md_In & (E_Md_Start_In | Md_Busy_Out);
    stall = data_stall | md_stall;
    Pause_Out = stall;
    D_Hold_Out = stall;
    E_Flush_Out = stall;
    Redirect_En_Out = ~stall;
  end
`ifdef STALL_PERF_EN
  logic [31:0] perf_data, perf_md;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      perf_data <= '0;
      perf_md <= '0;
    end else begin
      if (data_stall) perf_data <= perf_data + 32'd1;
      if (md_stall && !data_stall) perf_md <= perf_md + 32'd1;
    end
  assign Perf_Data_Stall_Out = perf_data;
  assign Perf_Md_Stall_Out = perf_md;
`else
  assign Perf_Data_Stall_Out = 32'h0;
  assign Perf_Md_Stall_Out = 32'h0;
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed checks of hazard stalls, mult/div busy tracking, reset and perf counters
module tb_stall_ctrl;
  logic Clk = 1'b0, Reset;
  logic [4:0] D_Rs_In, D_Rt_In, E_Wa_In, M_Wa_In;
  logic [1:0] D_Tuse_Rs_In, D_Tuse_Rt_In, E_Tnew_In, M_Tnew_In;
  logic D_Is_Md_In, E_Md_Start_In, E_Md_Type_In;
  logic Pause_Out, D_Hold_Out, E_Flush_Out, Redirect_En_Out, Md_Busy_Out;
  logic [31:0] Perf_Data_Stall_Out, Perf_Md_Stall_Out;
  int errors = 0, checks = 0;
  logic [31:0] exp_pd, exp_pm;

  stall_ctrl dut (
    .Clk(Clk), .Reset(Reset), .D_Rs_In(D_Rs_In), .D_Rt_In(D_Rt_In),
    .D_Tuse_Rs_In(D_Tuse_Rs_In), .D_Tuse_Rt_In(D_Tuse_Rt_In), .D_Is_Md_In(D_Is_Md_In),
    .E_Wa_In(E_Wa_In), .E_Tnew_In(E_Tnew_In), .M_Wa_In(M_Wa_In), .M_Tnew_In(M_Tnew_In),
    .E_Md_Start_In(E_Md_Start_In), .E_Md_Type_In(E_Md_Type_In), .Pause_Out(Pause_Out),
    .D_Hold_Out(D_Hold_Out), .E_Flush_Out(E_Flush_Out), .Redirect_En_Out(Redirect_En_Out),
    .Md_Busy_Out(Md_Busy_Out), .Perf_Data_Stall_Out(Perf_Data_Stall_Out),
    .Perf_Md_Stall_Out(Perf_Md_Stall_Out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic s);
    chk({tag, "_pause"}, 32'(Pause_Out), 32'(s));
    chk({tag, "_hold"}, 32'(D_Hold_Out), 32'(s));
    chk({tag, "_flush"}, 32'(E_Flush_Out), 32'(s));
    chk({tag, "_redir"}, 32'(Redirect_En_Out), 32'(!s));
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] pd, input logic [31:0] pm);
`ifdef STALL_PERF_EN
    chk({tag, "_perf_data"}, Perf_Data_Stall_Out, pd);
    chk({tag, "_perf_md"}, Perf_Md_Stall_Out, pm);
`else
    chk({tag, "_perf_data"}, Perf_Data_Stall_Out, 32'h0);
    chk({tag, "_perf_md"}, Perf_Md_Stall_Out, 32'h0);
`endif
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_hazard();
    D_Rs_In = 0; D_Rt_In = 0; D_Tuse_Rs_In = 2'd3; D_Tuse_Rt_In = 2'd3;
    E_Wa_In = 0; E_Tnew_In = 0; M_Wa_In = 0; M_Tnew_In = 0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_hazard();
    D_Is_Md_In = 0; E_Md_Start_In = 0; E_Md_Type_In = 0;
    #2;
    chk_stall("reset", 1'b0);
    chk("reset_busy", 32'(Md_Busy_Out), 0);
    chk_perf("reset", 0, 0);
    // Hazard and md start present during reset must still not stall
    D_Rs_In = 8; D_Tuse_Rs_In = 0; E_Wa_In = 8; E_Tnew_In = 2; D_Is_Md_In = 1; E_Md_Start_In = 1;
    #1;
    chk_stall("reset_forced", 1'b0);
    clear_hazard();
    D_Is_Md_In = 0; E_Md_Start_In = 0;
    tick();
    Reset = 1'b0;
    tick();
    chk_stall("idle", 1'b0);
    // Load-use: E producer two cycles away, then M producer one cycle away
    D_Rs_In = 8; D_Tuse_Rs_In = 0; E_Wa_In = 8; E_Tnew_In = 2;
    #1;
    chk_stall("lu_e", 1'b1);
    tick();
    E_Wa_In = 0; E_Tnew_In = 0; M_Wa_In = 8; M_Tnew_In = 1;
    #1;
    chk_stall("lu_m", 1'b1);
    tick();
    M_Wa_In = 0; M_Tnew_In = 0;
    #1;
    chk_stall("lu_done", 1'b0);
    exp_pd = 2; exp_pm = 0;
    chk_perf("lu", exp_pd, exp_pm);
    // Combinational boundary probes within one cycle, no edges
    clear_hazard();
    D_Rt_In = 5; D_Tuse_Rt_In = 1; M_Wa_In = 5; M_Tnew_In = 2;
    #1;
    chk_stall("rt_m", 1'b1);
    D_Tuse_Rt_In = 2'd3;
    #1;
    chk_stall("rt_unused", 1'b0);
    clear_hazard();
    D_Rs_In = 9; D_Tuse_Rs_In = 1; E_Wa_In = 9; E_Tnew_In = 1;
    #1;
    chk_stall("tnew_eq_tuse", 1'b0);
    clear_hazard();
    D_Rs_In = 0; D_Tuse_Rs_In = 0; E_Wa_In = 0; E_Tnew_In = 2;
    #1;
    chk_stall("reg_zero", 1'b0);
    clear_hazard();
    tick();
    // mult then mflo: start cycle stalls plus five busy cycles
    E_Md_Start_In = 1; E_Md_Type_In = 0; D_Is_Md_In = 1;
    #1;
    chk_stall("mult_start", 1'b1);
    chk("mult_start_busy", 32'(Md_Busy_Out), 0);
    tick();
    E_Md_Start_In = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_stall($sformatf("mult_busy%0d", i), 1'b1);
      chk($sformatf("mult_busy%0d_busy", i), 32'(Md_Busy_Out), 1);
      tick();
    end
    chk_stall("mult_done", 1'b0);
    chk("mult_done_busy", 32'(Md_Busy_Out), 0);
    exp_pm = 6;
    chk_perf("mult", exp_pd, exp_pm);
    D_Is_Md_In = 0;
    tick();
    // div followed by unrelated instructions: busy ten cycles, never stalls
    E_Md_Start_In = 1; E_Md_Type_In = 1;
    #1;
    chk_stall("div_start", 1'b0);
    tick();
    E_Md_Start_In = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("div_busy%0d", i), 32'(Md_Busy_Out), 1);
      chk_stall($sformatf("div_busy%0d", i), 1'b0);
      tick();
    end
    chk("div_done_busy", 32'(Md_Busy_Out), 0);
    chk_perf("div", exp_pd, exp_pm);
    // Reset mid-div when four cycles remain
    E_Md_Start_In = 1; E_Md_Type_In = 1;
    tick();
    E_Md_Start_In = 0;
    for (int i = 0; i < 6; i++) tick();
    D_Is_Md_In = 1;
    #1;
    chk("mid_div_busy", 32'(Md_Busy_Out), 1);
    chk_stall("mid_div", 1'b1);
    Reset = 1'b1;
    #1;
    chk("reset_async_busy", 32'(Md_Busy_Out), 0);
    chk_stall("reset_async", 1'b0);
    chk_perf("reset_async", 0, 0);
    tick();
    Reset = 1'b0;
    #1;
    chk("post_reset_busy", 32'(Md_Busy_Out), 0);
    chk_stall("post_reset", 1'b0);
    tick();
    chk("post_reset_idle", 32'(Md_Busy_Out), 0);
    chk_perf("post_reset", 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
